mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 111 +++++++++++
 tb/tb_mdu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Each result is computed at the accepting edge, then held back for a fixed Busy window.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDop,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles < 1) ? 1 : $clog2(MaxCycles + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [63:0]       res_q, res_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic              signed_op;
    logic [63:0]       a_ext, b_ext, prod;
    logic              a_neg, b_neg;
    logic [31:0]       a_mag, b_mag, uq, ur, quo, rem;

    // Even opcodes (mult, div) are the signed variants.
    assign signed_op = ~MDop[0];

    assign a_ext = {{32{signed_op & SrcA[31]}}, SrcA};
    assign b_ext = {{32{signed_op & SrcB[31]}}, SrcB};
    assign prod  = a_ext * b_ext;

    // Divide magnitudes, then restore signs; 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign a_neg = signed_op & SrcA[31];
    assign b_neg = signed_op & SrcB[31];
    assign a_mag = a_neg ? (32'd0 - SrcA) : SrcA;
    assign b_mag = b_neg ? (32'd0 - SrcB) : SrcB;
    assign uq    = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign ur    = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem   = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    case (MDop)
                        3'd0, 3'd1: begin
                            res_d   = prod;
                            state_d = StMul;
                            cnt_d   = CntW'(MULT_CYCLES - 1);
                        end
                        3'd2, 3'd3: begin
                            // A zero divisor commits the current HI/LO back unchanged.
                            res_d   = (SrcB == 32'd0) ? {hi_q, lo_q} : {rem, quo};
                            state_d = StDiv;
                            cnt_d   = CntW'(DIV_CYCLES - 1);
                        end
                        3'd4:    hi_d = SrcA;
                        3'd5:    lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                if (cnt_q == '0) begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q != StIdle);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a reference model pushes expected HI/LO and busy length
// to a scoreboard at issue time; entries are popped and compared when Busy drops.
module tb_mdu;

    localparam int MultCycles = 5;
    localparam int DivCycles  = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDop;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .MDop (MDop),
        .SrcA (SrcA),
        .SrcB (SrcB),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, written with native SV signed arithmetic.
    task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint pl;
        int     sa, sb;
        e.old_hi = model_hi;
        e.old_lo = model_lo;
        e.cycles = 0;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                pl = longint'($signed(a)) * longint'($signed(b));
                model_hi = pl[63:32];
                model_lo = pl[31:0];
                e.cycles = MultCycles;
            end
            3'd1: begin
                pl = longint'({32'd0, a}) * longint'({32'd0, b});
                model_hi = pl[63:32];
                model_lo = pl[31:0];
                e.cycles = MultCycles;
            end
            3'd2: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        model_lo = 32'h8000_0000;
                        model_hi = 32'd0;
                    end else begin
                        model_lo = sa / sb;
                        model_hi = sa % sb;
                    end
                end
                e.cycles = DivCycles;
            end
            3'd3: begin
                if (b != 32'd0) begin
                    model_lo = a / b;
                    model_hi = a % b;
                end
                e.cycles = DivCycles;
            end
            3'd4:    model_hi = a;
            3'd5:    model_lo = a;
            default: ;
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);
    endtask

    // Issue one op from a negedge, optionally pulse a second Start at busy cycle pulse_at,
    // then count busy cycles until the result appears and score it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at, input logic [2:0] pop,
                          input logic [31:0] pa);
        int   cnt;
        bit   done;
        exp_t e;
        push_exp(op, a, b);
        Start = 1'b1;
        MDop  = op;
        SrcA  = a;
        SrcB  = b;
        cnt   = 0;
        done  = 1'b0;
        e     = sb_q[0];
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Busy) begin
                cnt++;
                check({tag, "_hold_hi"}, 64'(HI), 64'(e.old_hi));
                check({tag, "_hold_lo"}, 64'(LO), 64'(e.old_lo));
                if (cnt == pulse_at) begin
                    Start = 1'b1;
                    MDop  = pop;
                    SrcA  = pa;
                    SrcB  = 32'd1;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check({tag, "_busy_timeout"}, 64'd1, 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_busy_cycles"}, 64'(cnt), 64'(e.cycles));
            check({tag, "_hi"}, 64'(HI), 64'(e.hi));
            check({tag, "_lo"}, 64'(LO), 64'(e.lo));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        // Reset with a simultaneous Start that must be ignored.
        Reset = 1'b1;
        Start = 1'b1;
        MDop  = 3'd0;
        SrcA  = 32'd5;
        SrcB  = 32'd5;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        @(negedge Clk);
        check("post_reset_busy", 64'(Busy), 64'd0);

        run_op("mult_m2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 32'd0);
        check("mult_m2x3_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_m2x3_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFA);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        check("multu_max_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFE);
        run_op("div_m7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0);
        check("div_m7by2_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        check("div_m7by2_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
        check("div_ovf_lo_const", 64'(LO), 64'h0000_0000_8000_0000);
        run_op("div_7bym2", 3'd2, 32'd7, 32'hFFFF_FFFE, 0, 3'd0, 32'd0);
        run_op("divu_100by7", 3'd3, 32'd100, 32'd7, 0, 3'd0, 32'd0);
        run_op("divu_big", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0);

        // Back-to-back mthi / mtlo.
        Start = 1'b1;
        MDop  = 3'd4;
        SrcA  = 32'h1234_5678;
        @(negedge Clk);
        check("mthi_busy", 64'(Busy), 64'd0);
        check("mthi_hi", 64'(HI), 64'h0000_0000_1234_5678);
        check("mthi_lo_kept", 64'(LO), 64'(model_lo));
        model_hi = 32'h1234_5678;
        MDop = 3'd5;
        SrcA = 32'h9ABC_DEF0;
        @(negedge Clk);
        Start = 1'b0;
        check("mtlo_busy", 64'(Busy), 64'd0);
        check("mtlo_lo", 64'(LO), 64'h0000_0000_9ABC_DEF0);
        check("mtlo_hi_kept", 64'(HI), 64'h0000_0000_1234_5678);
        model_lo = 32'h9ABC_DEF0;

        run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1, 0, 3'd0, 32'd0);
        run_op("nop7", 3'd7, 32'hCAFE_F00D, 32'd1, 0, 3'd0, 32'd0);

        // Divide by zero with a mtlo attempt inside the busy window.
        run_op("set_hi", 3'd4, 32'h11, 32'd0, 0, 3'd0, 32'd0);
        run_op("set_lo", 3'd5, 32'h22, 32'd0, 0, 3'd0, 32'd0);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, 3, 3'd5, 32'h55);
        check("divu_by0_hi_const", 64'(HI), 64'h11);
        check("divu_by0_lo_const", 64'(LO), 64'h22);
        run_op("div_by0", 3'd2, 32'hFFFF_FF00, 32'd0, 2, 3'd0, 32'd9);
        run_op("mult_ignored_pulse", 3'd0, 32'd9, 32'd9, 1, 3'd4, 32'hAAAA_AAAA);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) rb = 32'($urandom_range(1, 20)) | (rb & 32'h8000_0000);
            run_op("rand", rop, ra, rb, 0, 3'd0, 32'd0);
        end

        // Reset aborts an in-flight mult.
        run_op("pre_abort_hi", 3'd4, 32'h7777_0000, 32'd0, 0, 3'd0, 32'd0);
        Start = 1'b1;
        MDop  = 3'd0;
        SrcA  = 32'd7;
        SrcB  = 32'd6;
        repeat (3) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        check("abort_busy_before", 64'(Busy), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi", 64'(HI), 64'd0);
        check("abort_lo", 64'(LO), 64'd0);
        repeat (2) @(negedge Clk);
        check("abort_busy_later", 64'(Busy), 64'd0);
        check("abort_hi_later", 64'(HI), 64'd0);
        check("abort_lo_later", 64'(LO), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
